// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
//   Groups the operation handshake, the result registers and the data-memory
//   bus of the memory-access stage into one bundle.
//
//   Op side   : valid_in, z_in, y_in, mem_rd, mem_wr        (to stage)
//               z_reg_out, mdr_out, busy, done, err        (from stage)
//   Bus side  : mem_req, mem_we, mem_addr, mem_wdata       (from stage)
//               mem_rdata, mem_ack                         (to stage)
//
//   Modports: slave  = the stage itself
//             master = whoever drives ops and models memory (ALU side / bench)
// -----------------------------------------------------------------------------
interface mem_access_stage_if #(
   parameter int DW = 32
);
   logic          valid_in;
   logic [DW-1:0] z_in;
   logic [DW-1:0] y_in;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] z_reg_out;
   logic [DW-1:0] mdr_out;
   logic          busy;
   logic          done;
   logic          err;
   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport slave (
      input  valid_in, z_in, y_in, mem_rd, mem_wr, mem_rdata, mem_ack,
      output z_reg_out, mdr_out, busy, done, err,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output valid_in, z_in, y_in, mem_rd, mem_wr, mem_rdata, mem_ack,
      input  z_reg_out, mdr_out, busy, done, err,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Stage 4 of the multi-cycle datapath. Captures the ALU result into Z
//   (fed back to the ALU x-mux) and performs at most one word load/store per
//   operation over a req/ack data-memory bus; load data lands in MDR.
//
// Ports
//   clk        system clock, all state on posedge
//   reset      synchronous, active-high
//   m          mem_access_stage_if.slave: op handshake, Z/MDR, memory bus
//   state_dbg  current FSM state (IDLE=0, BUS=1, DONE=2) for observation
//
// Handshakes
//   Op: an op is accepted on a clk edge where valid_in=1 and busy=0. While
//   busy=1 valid_in is ignored (no queue). Completion is a single-cycle done
//   pulse; err belongs to that op and holds until the next accept.
//   Bus: mem_req rises in the first BUS cycle and stays high with addr/we/
//   wdata stable until a cycle with mem_ack=1 (one-cycle pulse) or until the
//   timeout limit; mem_ack outside BUS is ignored.
//
// Parameters
//   DW           data/address width, 32 in this datapath
//   TIMEOUT_CYC  max BUS cycles without mem_ack before giving up with err=1
//
// Configuration macro
//   ALIGN_CHECK_EN  defined  : load/store with z_in[1:0]!=0 completes with
//                              err=1 and no bus cycle (Z still loaded)
//                   undefined: address low two bits are forced to zero
// -----------------------------------------------------------------------------
module mem_access_stage #(
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                reset,
   mem_access_stage_if.slave   m,
   output logic [1:0]          state_dbg
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [DW-1:0]   z_q;
   logic [DW-1:0]   mdr_q;
   logic [DW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic            we_q;
   logic            err_q;
   logic [CW-1:0]   cnt_q;

   logic            accept;
   logic            one_op;
   logic            misaligned;
   logic            accept_err;
   logic            timeout;
   logic [CW-1:0]   cnt_plus;

   // Next-state and decode
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      one_op     = 1'b0;
      misaligned = 1'b0;
      accept_err = 1'b0;
      timeout    = 1'b0;
      cnt_plus   = cnt_q + 1'b1;

      accept = (state == S_IDLE) && m.valid_in;
      one_op = m.mem_rd ^ m.mem_wr;
`ifdef ALIGN_CHECK_EN
      misaligned = one_op && (m.z_in[1:0] != 2'b00);
`else
      misaligned = 1'b0;
`endif
      // rd and wr together is an illegal op: complete at once with error.
      accept_err = (m.mem_rd & m.mem_wr) | misaligned;

      // Ack on the cycle the limit would be reached still wins.
      timeout = (state == S_BUS) && !m.mem_ack &&
                (cnt_plus == CW'(TIMEOUT_CYC));

      case (state)
         S_IDLE: begin
            if (accept) begin
               if (one_op && !accept_err) state_next = S_BUS;
               else                       state_next = S_DONE;
            end
         end
         S_BUS: begin
            if (m.mem_ack || timeout) state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         z_q     <= '0;
         mdr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state <= state_next;

         if (accept) begin
            z_q     <= m.z_in;
            err_q   <= accept_err;
            // Word address: low bits never reach the bus.
            addr_q  <= {m.z_in[DW-1:2], 2'b00};
            wdata_q <= m.y_in;
            we_q    <= m.mem_wr;
            cnt_q   <= '0;
         end

         if (state == S_BUS) begin
            if (m.mem_ack) begin
               if (!we_q) mdr_q <= m.mem_rdata;
            end else begin
               cnt_q <= cnt_plus;
               if (timeout) err_q <= 1'b1;
            end
         end

         if (state == S_DONE) cnt_q <= '0;
      end
   end

   assign m.z_reg_out = z_q;
   assign m.mdr_out   = mdr_q;
   assign m.busy      = (state != S_IDLE);
   assign m.done      = (state == S_DONE);
   assign m.err       = err_q;
   assign m.mem_req   = (state == S_BUS);
   assign m.mem_we    = we_q;
   assign m.mem_addr  = addr_q;
   assign m.mem_wdata = wdata_q;
   assign state_dbg   = state;

endmodule
